// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: round-robin issue of two requesters into a fixed-latency FPU.
// Optional perf counters are built when FPU_ISSUE_PERF_EN is defined.
module fpu_issue_ctrl #(
  parameter int LATENCY = 4,
  parameter int MAX_OUT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [1:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [1:0]  req1_op,
  input  logic        drain,
  output logic        drain_done,
  output logic        fpu_valid,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  output logic [1:0]  fpu_op,
  input  logic [31:0] fpu_result,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [31:0] rsp_data
`ifdef FPU_ISSUE_PERF_EN
  ,
  output logic [31:0] perf_issued0,
  output logic [31:0] perf_issued1,
  output logic [31:0] perf_conflict
`endif
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    DRAINED = 2'd2
  } state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_OUT);

  state_t             state;
  logic               last_grant;
  logic               fpu_id;
  logic [3:0]         out0;
  logic [3:0]         out1;
  logic [LATENCY-1:0] tag_v;
  logic [LATENCY-1:0] tag_id;

  logic open_run;
  logic room0;
  logic room1;
  logic cand0;
  logic cand1;
  logic acc0;
  logic acc1;
  logic busy;

  // A response leaving this cycle frees its slot for an accept right now.
  assign open_run = (state == RUN) && !drain;
  assign room0    = (out0 < MAX_CNT) || rsp0_valid;
  assign room1    = (out1 < MAX_CNT) || rsp1_valid;
  assign cand0    = req0_valid && open_run && room0;
  assign cand1    = req1_valid && open_run && room1;

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (cand0 && cand1) begin
      req0_ready = last_grant;
      req1_ready = !last_grant;
    end else begin
      req0_ready = cand0;
      req1_ready = cand1;
    end
  end

  assign acc0 = req0_valid && req0_ready;
  assign acc1 = req1_valid && req1_ready;
  assign busy = fpu_valid || (|tag_v) || rsp0_valid || rsp1_valid;

  function automatic logic [3:0] next_cnt(
    input logic [3:0] c,
    input logic       inc,
    input logic       dec
  );
    case ({inc, dec})
      2'b10:   return c + 4'd1;
      2'b01:   return c - 4'd1;
      default: return c;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      drain_done <= 1'b0;
      last_grant <= 1'b1;
      out0       <= '0;
      out1       <= '0;
      fpu_valid  <= 1'b0;
      fpu_a      <= '0;
      fpu_b      <= '0;
      fpu_op     <= '0;
      fpu_id     <= 1'b0;
      tag_v      <= '0;
      tag_id     <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_data   <= '0;
    end else begin
      fpu_valid <= acc0 || acc1;
      if (acc0 || acc1) begin
        fpu_a      <= acc1 ? req1_a : req0_a;
        fpu_b      <= acc1 ? req1_b : req0_b;
        fpu_op     <= acc1 ? req1_op : req0_op;
        fpu_id     <= acc1;
        last_grant <= acc1;
      end

      tag_v[0]  <= fpu_valid;
      tag_id[0] <= fpu_id;
      for (int i = 1; i < LATENCY; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end

      rsp0_valid <= tag_v[LATENCY-1] && !tag_id[LATENCY-1];
      rsp1_valid <= tag_v[LATENCY-1] && tag_id[LATENCY-1];
      if (tag_v[LATENCY-1]) begin
        rsp_data <= fpu_result;
      end

      out0 <= next_cnt(out0, acc0, rsp0_valid);
      out1 <= next_cnt(out1, acc1, rsp1_valid);

      case (state)
        RUN: begin
          if (drain) state <= DRAIN;
        end
        DRAIN: begin
          if (!drain) begin
            state <= RUN;
          end else if (!busy) begin
            state      <= DRAINED;
            drain_done <= 1'b1;
          end
        end
        DRAINED: begin
          if (!drain) begin
            state      <= RUN;
            drain_done <= 1'b0;
          end
        end
        default: begin
          state      <= RUN;
          drain_done <= 1'b0;
        end
      endcase
    end
  end

`ifdef FPU_ISSUE_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issued0  <= '0;
      perf_issued1  <= '0;
      perf_conflict <= '0;
    end else begin
      perf_issued0  <= perf_issued0 + 32'(acc0);
      perf_issued1  <= perf_issued1 + 32'(acc1);
      perf_conflict <= perf_conflict + 32'(cand0 && cand1);
    end
  end
`endif

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: random + directed scoreboard bench for fpu_issue_ctrl.
// Reference model tracks in-flight ops per requester as a list of due cycles.
module tb_fpu_issue_ctrl;
  localparam int L = 4;
  localparam int M = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0;
  logic        req0_ready;
  logic [31:0] req0_a = '0;
  logic [31:0] req0_b = '0;
  logic [1:0]  req0_op = '0;
  logic        req1_valid = 1'b0;
  logic        req1_ready;
  logic [31:0] req1_a = '0;
  logic [31:0] req1_b = '0;
  logic [1:0]  req1_op = '0;
  logic        drain = 1'b0;
  logic        drain_done;
  logic        fpu_valid;
  logic [31:0] fpu_a;
  logic [31:0] fpu_b;
  logic [1:0]  fpu_op;
  logic [31:0] fpu_result;
  logic        rsp0_valid;
  logic        rsp1_valid;
  logic [31:0] rsp_data;
`ifdef FPU_ISSUE_PERF_EN
  logic [31:0] perf_issued0;
  logic [31:0] perf_issued1;
  logic [31:0] perf_conflict;
`endif

  fpu_issue_ctrl #(.LATENCY(L), .MAX_OUT(M)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .drain(drain), .drain_done(drain_done),
    .fpu_valid(fpu_valid), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_op(fpu_op), .fpu_result(fpu_result),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp_data(rsp_data)
`ifdef FPU_ISSUE_PERF_EN
    ,
    .perf_issued0(perf_issued0),
    .perf_issued1(perf_issued1),
    .perf_conflict(perf_conflict)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] fmodel(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [1:0]  op
  );
    if (op == 2'b00 && a == b) return a + 32'h0080_0000;
    return a ^ {b[30:0], b[31]} ^ {30'd0, op};
  endfunction

  // Behavioural FPU: L-stage data delay of the issued operands.
  logic [31:0] pipe [L];
  always @(posedge clk) begin
    pipe[0] <= fmodel(fpu_a, fpu_b, fpu_op);
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign fpu_result = pipe[L-1];

  typedef struct {
    bit          id;
    logic [31:0] data;
    int          due;
  } rsp_t;

  typedef enum { M_RUN, M_DRAIN, M_DRAINED } mode_t;

  rsp_t        sb[$];
  rsp_t        fly[$];
  int          nchk = 0;
  int          nerr = 0;
  bit          checking = 0;
  mode_t       mode = M_RUN;
  bit          last = 1'b1;
  bit          exp_fv = 1'b0;
  logic [31:0] ea, eb;
  logic [1:0]  eop;
  int          p0 = 0, p1 = 0, pc = 0;
  bit          fix_en = 0;
  logic [31:0] fix_a = '0, fix_b = '0;
  logic [1:0]  fix_op = '0;
  int          drain_left = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic int inflight(input bit id, input int t);
    int n = 0;
    foreach (fly[i]) if (fly[i].id == id && fly[i].due > t) n++;
    return n;
  endfunction

  function automatic bit pipe_empty(input int t);
    foreach (fly[i]) if (fly[i].due >= t) return 0;
    return 1;
  endfunction

  task automatic step(input bit v0, input bit v1, input bit drn, input bit r);
    bit e0, e1, c0, c1, g0, g1;
    logic [31:0] a, b;
    logic [1:0] op;
    rsp_t e;
    @(posedge clk);
    #1;
    rst = r;
    drain = drn;
    req0_valid = v0;
    req1_valid = v1;
    req0_a = $urandom; req0_b = $urandom; req0_op = 2'($urandom);
    req1_a = $urandom; req1_b = $urandom; req1_op = 2'($urandom);
    if (fix_en) begin
      req0_a = fix_a; req0_b = fix_b; req0_op = fix_op;
    end
    #4;
    if (checking) begin
      chk("fpu_valid", 32'(fpu_valid), 32'(exp_fv));
      if (exp_fv) begin
        chk("fpu_a", fpu_a, ea);
        chk("fpu_b", fpu_b, eb);
        chk("fpu_op", 32'(fpu_op), 32'(eop));
      end
      chk("drain_done", 32'(drain_done), 32'(mode == M_DRAINED));
    end
    e0 = (mode == M_RUN) && !drn && (inflight(0, cyc) < M);
    e1 = (mode == M_RUN) && !drn && (inflight(1, cyc) < M);
    c0 = v0 && e0;
    c1 = v1 && e1;
    if (c0 && c1) begin
      g0 = (last == 1'b1);
      g1 = !g0;
    end else begin
      g0 = c0;
      g1 = c1;
    end
    if (checking) begin
      chk("req0_ready", 32'(req0_ready), 32'(g0));
      chk("req1_ready", 32'(req1_ready), 32'(g1));
    end
    exp_fv = g0 || g1;
    if (exp_fv) begin
      a  = g1 ? req1_a : req0_a;
      b  = g1 ? req1_b : req0_b;
      op = g1 ? req1_op : req0_op;
      ea = a; eb = b; eop = op;
      e.id = g1;
      e.data = fmodel(a, b, op);
      e.due = cyc + L + 2;
      sb.push_back(e);
      fly.push_back(e);
      last = g1;
      if (g0) p0++;
      if (g1) p1++;
    end
    if (c0 && c1) pc++;
    if (r) begin
      mode = M_RUN;
      last = 1'b1;
      exp_fv = 1'b0;
      p0 = 0; p1 = 0; pc = 0;
      for (int i = sb.size() - 1; i >= 0; i--)
        if (sb[i].due > cyc) sb.delete(i);
      for (int i = fly.size() - 1; i >= 0; i--)
        if (fly[i].due > cyc) fly.delete(i);
    end else begin
      case (mode)
        M_RUN:     if (drn) mode = M_DRAIN;
        M_DRAIN:   if (!drn) mode = M_RUN;
                   else if (pipe_empty(cyc)) mode = M_DRAINED;
        M_DRAINED: if (!drn) mode = M_RUN;
        default:   mode = M_RUN;
      endcase
    end
    for (int i = fly.size() - 1; i >= 0; i--)
      if (fly[i].due <= cyc) fly.delete(i);
  endtask

  // Response monitor: pops the scoreboard whenever a response appears.
  initial begin
    rsp_t e;
    forever begin
      @(posedge clk);
      #3;
      if (checking) begin
        chk("rsp_both", 32'(rsp0_valid && rsp1_valid), 32'd0);
        if (rsp0_valid || rsp1_valid) begin
          if (sb.size() == 0) begin
            chk("rsp_unexpected", 32'(rsp0_valid | rsp1_valid), 32'd0);
          end else begin
            e = sb.pop_front();
            chk("rsp_id", 32'(rsp1_valid), 32'(e.id));
            chk("rsp_cycle", 32'(cyc), 32'(e.due));
            chk("rsp_data", rsp_data, e.data);
          end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
          e = sb.pop_front();
          chk("rsp_valid", 32'(rsp0_valid | rsp1_valid), 32'd1);
        end
      end
    end
  end

  initial begin
    bit v0, v1, dr, r;
    step(0, 0, 0, 1);
    checking = 1;
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_fpu_a", fpu_a, 32'd0);
    chk("rst_rsp0", 32'(rsp0_valid), 32'd0);

    // Both requesters contend from reset: grants must alternate 0,1,0,1.
    repeat (8) step(1, 1, 0, 0);
    step(0, 0, 0, 0);
`ifdef FPU_ISSUE_PERF_EN
    chk("perf_issued0", perf_issued0, 32'd4);
    chk("perf_issued1", perf_issued1, 32'd4);
    chk("perf_conflict", perf_conflict, 32'd8);
`endif
    repeat (10) step(0, 0, 0, 0);

    fix_en = 1;
    fix_a = 32'h3F80_0000; fix_b = 32'h3F80_0000; fix_op = 2'b00;
    step(1, 0, 0, 0);
    fix_en = 0;
    repeat (L + 4) step(0, 0, 0, 0);
    chk("single_data", rsp_data, 32'h4000_0000);

    repeat (14) step(1, 0, 0, 0);
    repeat (10) step(0, 0, 0, 0);

    repeat (3) step(1, 0, 0, 0);
    for (int k = 0; k < 30 && mode != M_DRAINED; k++) step(1, 1, 1, 0);
    step(1, 1, 1, 0);
    chk("drain_done_set", 32'(drain_done), 32'd1);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    repeat (10) step(0, 0, 0, 0);

    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    repeat (12) step(0, 0, 0, 0);

    for (int k = 0; k < 500; k++) begin
      v0 = ($urandom % 4) != 0;
      v1 = ($urandom % 3) != 0;
      if (drain_left > 0) begin
        drain_left--;
        dr = 1;
      end else if ($urandom % 25 == 0) begin
        drain_left = $urandom_range(1, 16);
        dr = 1;
      end else begin
        dr = 0;
      end
      r = ($urandom % 200) == 0;
      if (r) begin
        v0 = 0;
        v1 = 0;
      end
      step(v0, v1, dr, r);
    end

    for (int k = 0; k < 60 && sb.size() > 0; k++) step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("sb_empty", 32'(sb.size()), 32'd0);
`ifdef FPU_ISSUE_PERF_EN
    chk("perf_issued0_end", perf_issued0, 32'(p0));
    chk("perf_issued1_end", perf_issued1, 32'(p1));
    chk("perf_conflict_end", perf_conflict, 32'(pc));
`endif
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
